// File: rtl/move_ctrl.sv
// Active-piece movement controller: queues spawn, gravity and user requests,
// runs one move check at a time and applies the verdict to the piece register.
module move_ctrl #(
  parameter int FIELD_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spawn_i,
  input  logic [26:0] spawn_block_i,
  input  logic        gravity_tick_i,
  input  logic        user_move_valid_i,
  input  logic [2:0]  user_move_i,
  output logic        user_ready_o,
  output logic        check_run_o,
  output logic [2:0]  check_req_move_o,
  output logic [26:0] check_block_o,
  input  logic        check_done_i,
  input  logic        check_can_move_i,
  input  logic [1:0]  check_move_x_i,
  input  logic [1:0]  check_move_y_i,
  output logic [26:0] block_o,
  output logic        block_valid_o,
  output logic        block_upd_o,
  output logic        lock_o,
  output logic        move_rej_o,
  output logic        game_over_o
);

  // state   | meaning
  // IDLE    | arbitrate pending requests, discard moves without a live piece
  // RUN     | one-cycle start pulse to the checker
  // WAIT    | hold request stable until the checker reports done
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_SPAWN = 2'd1,
    SEL_GRAV  = 2'd2,
    SEL_USER  = 2'd3
  } sel_t;

  localparam logic [2:0] MOVE_LEFT   = 3'd0;
  localparam logic [2:0] MOVE_RIGHT  = 3'd1;
  localparam logic [2:0] MOVE_ROTATE = 3'd2;
  localparam logic [2:0] MOVE_DOWN   = 3'd3;
  localparam logic [2:0] MOVE_APPEAR = 3'd4;

  localparam logic signed [5:0] FW_S = 6'(FIELD_W);

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  rot;
    logic [4:0]  y;
    logic [3:0]  x;
  } block_info_t;

  state_t      state_q;
  state_t      state_d;
  sel_t        sel;

  logic        spawn_pend_q;
  block_info_t spawn_buf_q;
  logic        grav_pend_q;
  logic        user_pend_q;
  logic [2:0]  user_buf_q;
  logic        user_acc;

  block_info_t blk_q;
  block_info_t blk_moved;
  logic [2:0]  req_q;
  logic        valid_q;
  logic        upd_q;
  logic        lock_q;
  logic        rej_q;
  logic        go_q;
  logic        done_ev;

  logic signed [5:0] x_sum;
  logic signed [5:0] x_fix;

  assign user_acc = user_move_valid_i & ~user_pend_q & ~go_q;
  assign done_ev  = (state_q == ST_WAIT) & check_done_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moves without a live piece are consumed here without leaving IDLE.
  always_comb begin
    state_d = state_q;
    sel     = SEL_NONE;
    case (state_q)
      ST_IDLE: begin
        if (!go_q) begin
          if (spawn_pend_q) begin
            sel     = SEL_SPAWN;
            state_d = ST_RUN;
          end else if (grav_pend_q) begin
            sel = SEL_GRAV;
            if (valid_q) state_d = ST_RUN;
          end else if (user_pend_q) begin
            sel = SEL_USER;
            if (valid_q) state_d = ST_RUN;
          end
        end
      end
      ST_RUN:  state_d = ST_WAIT;
      ST_WAIT: if (check_done_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    check_run_o = (state_q == ST_RUN);
  end

  // A fresh request arriving on the same cycle it is being selected wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spawn_pend_q <= 1'b0;
      spawn_buf_q  <= '0;
      grav_pend_q  <= 1'b0;
      user_pend_q  <= 1'b0;
      user_buf_q   <= '0;
    end else begin
      if (spawn_i && !go_q) begin
        spawn_pend_q <= 1'b1;
        spawn_buf_q  <= spawn_block_i;
      end else if (sel == SEL_SPAWN) begin
        spawn_pend_q <= 1'b0;
      end

      if (gravity_tick_i && !go_q) begin
        grav_pend_q <= 1'b1;
      end else if (sel == SEL_GRAV) begin
        grav_pend_q <= 1'b0;
      end

      if (user_acc) begin
        user_pend_q <= 1'b1;
        user_buf_q  <= user_move_i;
      end else if (sel == SEL_USER) begin
        user_pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    blk_moved = blk_q;
    x_sum     = $signed({2'b00, blk_q.x}) + $signed({{4{check_move_x_i[1]}}, check_move_x_i});
    x_fix     = x_sum;
    if (x_sum < 6'sd0) begin
      x_fix = x_sum + FW_S;
    end else if (x_sum >= FW_S) begin
      x_fix = x_sum - FW_S;
    end
    blk_moved.x = x_fix[3:0];
    blk_moved.y = blk_q.y + {{3{check_move_y_i[1]}}, check_move_y_i};
    if (req_q == MOVE_ROTATE) begin
      blk_moved.rot = blk_q.rot + 2'd1;
    end
  end

  // Result pulses are registered so they appear one cycle after done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_q   <= '0;
      req_q   <= MOVE_LEFT;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      lock_q  <= 1'b0;
      rej_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      upd_q  <= 1'b0;
      lock_q <= 1'b0;
      rej_q  <= 1'b0;

      if (state_d == ST_RUN) begin
        case (sel)
          SEL_SPAWN: begin
            blk_q <= spawn_buf_q;
            req_q <= MOVE_APPEAR;
          end
          SEL_GRAV: req_q <= MOVE_DOWN;
          SEL_USER: req_q <= user_buf_q;
          default:  req_q <= req_q;
        endcase
      end

      if (done_ev) begin
        if (check_can_move_i) begin
          blk_q <= blk_moved;
          upd_q <= 1'b1;
          if (req_q == MOVE_APPEAR) valid_q <= 1'b1;
        end else begin
          case (req_q)
            MOVE_APPEAR: begin
              go_q    <= 1'b1;
              valid_q <= 1'b0;
              upd_q   <= 1'b1;
            end
            MOVE_DOWN: begin
              lock_q  <= 1'b1;
              valid_q <= 1'b0;
            end
            default: rej_q <= 1'b1;
          endcase
        end
      end
    end
  end

  assign user_ready_o     = ~user_pend_q;
  assign check_req_move_o = req_q;
  assign check_block_o    = blk_q;
  assign block_o          = blk_q;
  assign block_valid_o    = valid_q;
  assign block_upd_o      = upd_q;
  assign lock_o           = lock_q;
  assign move_rej_o       = rej_q;
  assign game_over_o      = go_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level model of the request rules.
module tb_move_ctrl;
  localparam int FW = 10;
  localparam logic [2:0] MV_LEFT = 3'd0, MV_RIGHT = 3'd1, MV_ROT = 3'd2,
                         MV_DOWN = 3'd3, MV_APPEAR = 3'd4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        spawn_i, gravity_tick_i, user_move_valid_i;
  logic [26:0] spawn_block_i;
  logic [2:0]  user_move_i;
  logic        user_ready_o, check_run_o;
  logic [2:0]  check_req_move_o;
  logic [26:0] check_block_o, block_o;
  logic        check_done_i, check_can_move_i;
  logic [1:0]  check_move_x_i, check_move_y_i;
  logic        block_valid_o, block_upd_o, lock_o, move_rej_o, game_over_o;

  move_ctrl #(.FIELD_W(FW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .spawn_i(spawn_i), .spawn_block_i(spawn_block_i),
    .gravity_tick_i(gravity_tick_i), .user_move_valid_i(user_move_valid_i),
    .user_move_i(user_move_i), .user_ready_o(user_ready_o), .check_run_o(check_run_o),
    .check_req_move_o(check_req_move_o), .check_block_o(check_block_o),
    .check_done_i(check_done_i), .check_can_move_i(check_can_move_i),
    .check_move_x_i(check_move_x_i), .check_move_y_i(check_move_y_i),
    .block_o(block_o), .block_valid_o(block_valid_o), .block_upd_o(block_upd_o),
    .lock_o(lock_o), .move_rej_o(move_rej_o), .game_over_o(game_over_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int run_cnt = 0;

  always @(posedge clk_i) if (check_run_o) run_cnt <= run_cnt + 1;

  typedef struct {int x; int y; int r; int d;} blk_t;

  typedef struct {
    logic [2:0] mv; int x0; int y0; int r0;
    logic can; logic [1:0] mx; logic [1:0] my;
    int ex; int ey; int er;
    logic ev; logic eupd; logic elock; logic erej; logic ego;
  } vec_t;

  vec_t vecs[10];

  // transaction-level model state
  blk_t       m_blk, m_sp_buf;
  logic       m_valid, m_go, m_sp_pend, m_gr_pend, m_us_pend;
  logic [2:0] m_us_mv;
  logic       e_upd, e_lock, e_rej;

  function automatic blk_t mk(input int x, input int y, input int r, input int d);
    blk_t b;
    b.x = x; b.y = y; b.r = r; b.d = d;
    return b;
  endfunction

  function automatic logic [26:0] pk(input blk_t b);
    logic [26:0] v;
    v = {b.d[15:0], b.r[1:0], b.y[4:0], b.x[3:0]};
    return v;
  endfunction

  function automatic blk_t rand_blk();
    return mk($urandom_range(0, FW - 1), $urandom_range(0, 31), $urandom_range(0, 3),
              $urandom_range(0, 65535));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
    spawn_i = 1'b0;
    gravity_tick_i = 1'b0;
    user_move_valid_i = 1'b0;
    check_done_i = 1'b0;
  endtask

  task automatic m_reset();
    m_blk = mk(0, 0, 0, 0);
    m_sp_buf = mk(0, 0, 0, 0);
    m_valid = 1'b0; m_go = 1'b0;
    m_sp_pend = 1'b0; m_gr_pend = 1'b0; m_us_pend = 1'b0; m_us_mv = MV_LEFT;
  endtask

  task automatic do_reset();
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    m_reset();
  endtask

  // mode 1: three gravity ticks during WAIT; mode 2: random model-tracked requests
  task automatic inject(input int mode, input int i);
    blk_t b;
    logic [2:0] mv;
    if (mode == 1 && (i == 3 || i == 5 || i == 7)) gravity_tick_i = 1'b1;
    if (mode == 2) begin
      if ((i == 3 || i == 5 || i == 7) && $urandom_range(0, 2) == 0) begin
        gravity_tick_i = 1'b1;
        m_gr_pend = 1'b1;
      end
      if ((i == 4 || i == 6) && $urandom_range(0, 3) == 0) begin
        b = rand_blk();
        spawn_i = 1'b1;
        spawn_block_i = pk(b);
        m_sp_pend = 1'b1;
        m_sp_buf = b;
      end
      if (i == 8 && $urandom_range(0, 2) == 0) begin
        chk("ready_wait", user_ready_o, !m_us_pend);
        mv = 3'($urandom_range(0, 3));
        user_move_valid_i = 1'b1;
        user_move_i = mv;
        if (!m_us_pend) begin
          m_us_pend = 1'b1;
          m_us_mv = mv;
        end
      end
    end
  endtask

  // Waits for the check, answers done 17 cycles after the run pulse, returns
  // at the cycle where result pulses are visible.
  task automatic do_check(input logic [2:0] em, input logic [26:0] eb, input logic can,
                          input logic [1:0] mx, input logic [1:0] my, input int mode);
    int w;
    w = 0;
    while (!check_run_o && w < 12) begin
      cyc();
      w++;
    end
    chk("run_seen", check_run_o, 1);
    if (!check_run_o) return;
    chk("req_move", check_req_move_o, em);
    chk("chk_block", check_block_o, eb);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 1) chk("run_one_cycle", check_run_o, 0);
      inject(mode, i);
    end
    cyc();
    chk("req_stable", check_req_move_o, em);
    chk("blk_stable", check_block_o, eb);
    check_done_i = 1'b1;
    check_can_move_i = can;
    check_move_x_i = mx;
    check_move_y_i = my;
    cyc();
  endtask

  task automatic m_apply(input logic [2:0] mv, input logic can, input logic [1:0] mx,
                         input logic [1:0] my);
    int dx, dy;
    e_upd = 1'b0; e_lock = 1'b0; e_rej = 1'b0;
    dx = mx[1] ? int'(mx) - 4 : int'(mx);
    dy = my[1] ? int'(my) - 4 : int'(my);
    if (can) begin
      m_blk.x = ((m_blk.x + dx) % FW + FW) % FW;
      m_blk.y = ((m_blk.y + dy) % 32 + 32) % 32;
      if (mv == MV_ROT) m_blk.r = (m_blk.r + 1) % 4;
      if (mv == MV_APPEAR) m_valid = 1'b1;
      e_upd = 1'b1;
    end else if (mv == MV_APPEAR) begin
      m_go = 1'b1; m_valid = 1'b0; e_upd = 1'b1;
    end else if (mv == MV_DOWN) begin
      e_lock = 1'b1; m_valid = 1'b0;
    end else begin
      e_rej = 1'b1;
    end
  endtask

  task automatic m_serve();
    logic [2:0] mv;
    logic can;
    logic [1:0] mx, my;
    while (!m_go && (m_sp_pend || m_gr_pend || m_us_pend)) begin
      if (m_sp_pend) begin
        m_sp_pend = 1'b0; m_blk = m_sp_buf; mv = MV_APPEAR;
      end else if (m_gr_pend) begin
        m_gr_pend = 1'b0; mv = MV_DOWN;
        if (!m_valid) continue;
      end else begin
        m_us_pend = 1'b0; mv = m_us_mv;
        if (!m_valid) continue;
      end
      if (mv == MV_APPEAR) can = ($urandom_range(0, 7) != 0);
      else if (mv == MV_DOWN) can = ($urandom_range(0, 3) != 0);
      else can = 1'($urandom_range(0, 1));
      mx = 2'($urandom_range(0, 3));
      my = 2'($urandom_range(0, 3));
      do_check(mv, pk(m_blk), can, mx, my, 2);
      m_apply(mv, can, mx, my);
      chk("m_block", block_o, pk(m_blk));
      chk("m_valid", block_valid_o, m_valid);
      chk("m_upd", block_upd_o, e_upd);
      chk("m_lock", lock_o, e_lock);
      chk("m_rej", move_rej_o, e_rej);
      chk("m_go", game_over_o, m_go);
    end
  endtask

  task automatic rand_round();
    blk_t b;
    int c;
    if (m_go) begin
      c = run_cnt;
      spawn_i = 1'b1; spawn_block_i = pk(rand_blk());
      gravity_tick_i = 1'b1;
      user_move_valid_i = 1'b1; user_move_i = MV_DOWN;
      repeat (8) cyc();
      chk("go_no_run", run_cnt - c, 0);
      chk("go_sticky", game_over_o, 1);
      do_reset();
      return;
    end
    if (!m_valid ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0)) begin
      b = rand_blk();
      spawn_i = 1'b1; spawn_block_i = pk(b);
      m_sp_pend = 1'b1; m_sp_buf = b;
    end
    if ($urandom_range(0, 1) == 1) begin
      gravity_tick_i = 1'b1;
      m_gr_pend = 1'b1;
    end
    if ($urandom_range(0, 1) == 1) begin
      chk("ready_idle", user_ready_o, !m_us_pend);
      user_move_valid_i = 1'b1;
      m_us_mv = 3'($urandom_range(0, 3));
      user_move_i = m_us_mv;
      m_us_pend = 1'b1;
    end
    m_serve();
    c = run_cnt;
    repeat (4) cyc();
    chk("idle_quiet", run_cnt - c, 0);
  endtask

  task automatic run_table();
    vec_t v;
    blk_t b;
    for (int k = 0; k < 10; k++) begin
      v = vecs[k];
      b = mk(v.x0, v.y0, v.r0, 16'hA5C3);
      do_reset();
      spawn_i = 1'b1; spawn_block_i = pk(b);
      do_check(MV_APPEAR, pk(b), 1'b1, 2'b00, 2'b00, 0);
      case (v.mv)
        MV_APPEAR: begin spawn_i = 1'b1; spawn_block_i = pk(b); end
        MV_DOWN:   gravity_tick_i = 1'b1;
        default:   begin user_move_valid_i = 1'b1; user_move_i = v.mv; end
      endcase
      do_check(v.mv, pk(b), v.can, v.mx, v.my, 0);
      chk($sformatf("vec%0d_block", k), block_o, pk(mk(v.ex, v.ey, v.er, 16'hA5C3)));
      chk($sformatf("vec%0d_valid", k), block_valid_o, v.ev);
      chk($sformatf("vec%0d_upd", k), block_upd_o, v.eupd);
      chk($sformatf("vec%0d_lock", k), lock_o, v.elock);
      chk($sformatf("vec%0d_rej", k), move_rej_o, v.erej);
      chk($sformatf("vec%0d_go", k), game_over_o, v.ego);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, user_ready_o, 1);
    chk({tag, "_run"}, check_run_o, 0);
    chk({tag, "_req"}, check_req_move_o, 0);
    chk({tag, "_cblk"}, check_block_o, 0);
    chk({tag, "_blk"}, block_o, 0);
    chk({tag, "_valid"}, block_valid_o, 0);
    chk({tag, "_upd"}, block_upd_o, 0);
    chk({tag, "_lock"}, lock_o, 0);
    chk({tag, "_rej"}, move_rej_o, 0);
    chk({tag, "_go"}, game_over_o, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int w;
    blk_t b;
    //        mv         x0 y0 r0 can  mx     my     ex ey er ev    upd   lock  rej   go
    vecs[0] = '{MV_LEFT,   3, 0, 0, 1'b1, 2'b11, 2'b00, 2, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{MV_RIGHT,  9, 5, 1, 1'b1, 2'b01, 2'b00, 0, 5, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{MV_LEFT,   0, 2, 2, 1'b1, 2'b11, 2'b00, 9, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{MV_ROT,    4, 4, 3, 1'b1, 2'b00, 2'b00, 4, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{MV_DOWN,   6, 7, 1, 1'b1, 2'b00, 2'b01, 6, 8, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{MV_DOWN,   6, 7, 2, 1'b0, 2'b00, 2'b01, 6, 7, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{MV_LEFT,   5, 3, 0, 1'b0, 2'b11, 2'b00, 5, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{MV_ROT,    5, 3, 1, 1'b0, 2'b00, 2'b00, 5, 3, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{MV_APPEAR, 2, 0, 0, 1'b0, 2'b00, 2'b00, 2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{MV_RIGHT,  1, 9, 0, 1'b1, 2'b10, 2'b11, 9, 8, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_i = 1'b1;
    spawn_i = 0; spawn_block_i = '0; gravity_tick_i = 0;
    user_move_valid_i = 0; user_move_i = '0;
    check_done_i = 0; check_can_move_i = 0; check_move_x_i = '0; check_move_y_i = '0;
    m_reset();
    #1;
    chk_reset_outs("rst0");
    cyc();
    rst_i = 1'b0;

    run_table();

    // spawn, then gravity and user RIGHT together, then ticks collapse
    do_reset();
    c = run_cnt;
    spawn_i = 1'b1; spawn_block_i = pk(mk(3, 0, 0, 16'h1234));
    do_check(MV_APPEAR, pk(mk(3, 0, 0, 16'h1234)), 1'b1, 2'b00, 2'b00, 0);
    chk("sp_block", block_o, pk(mk(3, 0, 0, 16'h1234)));
    chk("sp_valid", block_valid_o, 1);
    chk("sp_upd", block_upd_o, 1);
    cyc();
    chk("sp_upd_once", block_upd_o, 0);
    chk("sp_runs", run_cnt - c, 1);
    c = run_cnt;
    gravity_tick_i = 1'b1;
    user_move_valid_i = 1'b1; user_move_i = MV_RIGHT;
    do_check(MV_DOWN, pk(mk(3, 0, 0, 16'h1234)), 1'b1, 2'b00, 2'b01, 0);
    do_check(MV_RIGHT, pk(mk(3, 1, 0, 16'h1234)), 1'b1, 2'b01, 2'b00, 1);
    do_check(MV_DOWN, pk(mk(4, 1, 0, 16'h1234)), 1'b1, 2'b00, 2'b01, 0);
    chk("arb_block", block_o, pk(mk(4, 2, 0, 16'h1234)));
    repeat (6) cyc();
    chk("arb_runs", run_cnt - c, 3);

    // lock, then user move on a dead piece is dropped
    gravity_tick_i = 1'b1;
    do_check(MV_DOWN, pk(mk(4, 2, 0, 16'h1234)), 1'b0, 2'b00, 2'b01, 0);
    chk("lk_lock", lock_o, 1);
    chk("lk_valid", block_valid_o, 0);
    chk("lk_block", block_o, pk(mk(4, 2, 0, 16'h1234)));
    cyc();
    chk("lk_once", lock_o, 0);
    c = run_cnt;
    user_move_valid_i = 1'b1; user_move_i = MV_LEFT;
    repeat (8) cyc();
    chk("lk_discard", run_cnt - c, 0);
    chk("lk_ready", user_ready_o, 1);

    // game over is sticky until reset
    do_reset();
    spawn_i = 1'b1; spawn_block_i = pk(mk(5, 0, 0, 16'h00FF));
    do_check(MV_APPEAR, pk(mk(5, 0, 0, 16'h00FF)), 1'b0, 2'b00, 2'b00, 0);
    chk("go_set", game_over_o, 1);
    chk("go_valid", block_valid_o, 0);
    chk("go_upd", block_upd_o, 1);
    c = run_cnt;
    spawn_i = 1'b1; gravity_tick_i = 1'b1;
    user_move_valid_i = 1'b1; user_move_i = MV_ROT;
    repeat (8) cyc();
    chk("go_quiet", run_cnt - c, 0);
    chk("go_hold", game_over_o, 1);
    cyc();
    rst_i = 1'b1;
    #1;
    chk("go_clear", game_over_o, 0);
    cyc();
    rst_i = 1'b0;

    // reset in the middle of WAIT, then a stale done
    m_reset();
    spawn_i = 1'b1; spawn_block_i = pk(mk(7, 3, 1, 16'hBEEF));
    w = 0;
    while (!check_run_o && w < 12) begin
      cyc();
      w++;
    end
    chk("ab_run", check_run_o, 1);
    repeat (6) cyc();
    rst_i = 1'b1;
    #1;
    chk_reset_outs("ab");
    cyc();
    rst_i = 1'b0;
    c = run_cnt;
    repeat (10) cyc();
    check_done_i = 1'b1; check_can_move_i = 1'b1;
    check_move_x_i = 2'b01; check_move_y_i = 2'b01;
    cyc();
    chk("ab_upd", block_upd_o, 0);
    chk("ab_block", block_o, 0);
    chk("ab_valid", block_valid_o, 0);
    cyc();
    chk("ab_runs", run_cnt - c, 0);

    do_reset();
    for (int r = 0; r < 60; r++) rand_round();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
